// File: rtl/vga_pkg.sv
// Shared types and timing presets for the VGA pipeline.
// Holds the runtime timing record, the 1024x768 and 640x480 presets, and the
// legality check used when VGA_TIMING_CFG_CHECK_EN is defined.
package vga_pkg;

    localparam int VGA_CNT_W = 11;

    typedef logic [VGA_CNT_W-1:0] vga_cnt_t;

    typedef struct packed {
        vga_cnt_t h_total;
        vga_cnt_t h_blank_start;
        vga_cnt_t h_sync_start;
        vga_cnt_t h_sync_stop;
        vga_cnt_t v_total;
        vga_cnt_t v_blank_start;
        vga_cnt_t v_sync_start;
        vga_cnt_t v_sync_stop;
    } vga_cfg_t;

    localparam vga_cfg_t VGA_CFG_1024X768 = '{
        h_total: vga_cnt_t'(1344), h_blank_start: vga_cnt_t'(1024),
        h_sync_start: vga_cnt_t'(1048), h_sync_stop: vga_cnt_t'(1184),
        v_total: vga_cnt_t'(806), v_blank_start: vga_cnt_t'(768),
        v_sync_start: vga_cnt_t'(771), v_sync_stop: vga_cnt_t'(777)};

    localparam vga_cfg_t VGA_CFG_640X480 = '{
        h_total: vga_cnt_t'(800), h_blank_start: vga_cnt_t'(640),
        h_sync_start: vga_cnt_t'(656), h_sync_stop: vga_cnt_t'(752),
        v_total: vga_cnt_t'(525), v_blank_start: vga_cnt_t'(480),
        v_sync_start: vga_cnt_t'(490), v_sync_stop: vga_cnt_t'(492)};

    // A timing set is usable when each axis has at least two positions, every
    // edge lies within the axis, and the sync pulse is at least one unit wide.
    function automatic logic vga_cfg_legal(input vga_cfg_t c);
        return (c.h_total >= vga_cnt_t'(2)) && (c.v_total >= vga_cnt_t'(2)) &&
               (c.h_blank_start <= c.h_total) && (c.h_sync_start <= c.h_total) &&
               (c.h_sync_stop <= c.h_total) && (c.v_blank_start <= c.v_total) &&
               (c.v_sync_start <= c.v_total) && (c.v_sync_stop <= c.v_total) &&
               (c.h_sync_stop > c.h_sync_start) && (c.v_sync_stop > c.v_sync_start);
    endfunction

endpackage

// File: rtl/vga_tim_axis.sv
// One timing axis (horizontal or vertical): next count, wrap, and the
// blank/sync levels decoded from the next count. Sync is active-high here;
// polarity is applied by the caller.
module vga_tim_axis #(
    parameter int CNT_W = 11
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] blank_start,
    input  logic [CNT_W-1:0] sync_start,
    input  logic [CNT_W-1:0] sync_stop,
    input  logic             inc,
    output logic [CNT_W-1:0] count_nxt,
    output logic             wrap,
    output logic             blnk_nxt,
    output logic             sync_nxt
);

    // Wrap is judged against the config that produced the current count.
    assign wrap = inc && (count == total - CNT_W'(1));

    // Step the counter, returning to zero at the last position.
    always_comb begin
        count_nxt = count;
        if (inc) count_nxt = wrap ? '0 : count + CNT_W'(1);
    end

    // Counts never pass total-1, so the blank interval only needs its lower edge.
    assign blnk_nxt = (count_nxt >= blank_start);
    assign sync_nxt = (count_nxt >= sync_start) && (count_nxt < sync_stop);

endmodule

// File: rtl/vga_timing_prog.sv
// Runtime-programmable VGA timing generator.
// Timing is loaded into a one-deep shadow over a valid/ready port and becomes
// active on the advance that lands on (0,0). Define VGA_TIMING_CFG_CHECK_EN to
// reject illegal timing sets at transfer time (cfg_err pulses instead).
module vga_timing_prog
    import vga_pkg::*;
#(
    parameter int       CNT_W     = VGA_CNT_W,
    parameter bit       HSYNC_POL = 1'b1,
    parameter bit       VSYNC_POL = 1'b1,
    parameter vga_cfg_t RST_CFG   = VGA_CFG_1024X768
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  vga_cfg_t         cfg_in,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblnk,
    output logic             vblnk,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic             line_start,
    output logic             cfg_err
);

    vga_cfg_t         act_cfg;
    vga_cfg_t         shd_cfg;
    logic             shd_full;
    logic             cfg_ok;
    logic             accept;
    logic             reject;
    logic             apply;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             h_wrap, v_wrap;
    logic             hb_nxt, vb_nxt, hs_nxt, vs_nxt;
    logic [CNT_W-1:0] dec_hbs, dec_hss, dec_hse, dec_vbs, dec_vss, dec_vse;

`ifdef VGA_TIMING_CFG_CHECK_EN
    assign cfg_ok = vga_cfg_legal(cfg_in);
`else
    assign cfg_ok = 1'b1;
`endif

    // The shadow is occupied exactly when the port is not ready.
    assign shd_full = ~cfg_ready;
    assign accept   = cfg_valid & cfg_ready & cfg_ok;
    assign reject   = cfg_valid & cfg_ready & ~cfg_ok;

    // Frame wrap with a pending shadow: the (0,0) flags must already use it.
    assign apply   = h_wrap & v_wrap & shd_full;
    assign dec_hbs = CNT_W'(apply ? shd_cfg.h_blank_start : act_cfg.h_blank_start);
    assign dec_hss = CNT_W'(apply ? shd_cfg.h_sync_start  : act_cfg.h_sync_start);
    assign dec_hse = CNT_W'(apply ? shd_cfg.h_sync_stop   : act_cfg.h_sync_stop);
    assign dec_vbs = CNT_W'(apply ? shd_cfg.v_blank_start : act_cfg.v_blank_start);
    assign dec_vss = CNT_W'(apply ? shd_cfg.v_sync_start  : act_cfg.v_sync_start);
    assign dec_vse = CNT_W'(apply ? shd_cfg.v_sync_stop   : act_cfg.v_sync_stop);

    vga_tim_axis #(.CNT_W(CNT_W)) u_h (
        .count       (hcount),
        .total       (CNT_W'(act_cfg.h_total)),
        .blank_start (dec_hbs),
        .sync_start  (dec_hss),
        .sync_stop   (dec_hse),
        .inc         (en),
        .count_nxt   (h_nxt),
        .wrap        (h_wrap),
        .blnk_nxt    (hb_nxt),
        .sync_nxt    (hs_nxt)
    );

    vga_tim_axis #(.CNT_W(CNT_W)) u_v (
        .count       (vcount),
        .total       (CNT_W'(act_cfg.v_total)),
        .blank_start (dec_vbs),
        .sync_start  (dec_vss),
        .sync_stop   (dec_vse),
        .inc         (h_wrap),
        .count_nxt   (v_nxt),
        .wrap        (v_wrap),
        .blnk_nxt    (vb_nxt),
        .sync_nxt    (vs_nxt)
    );

    // Position and video flags: advance on en, otherwise hold with strobes low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            de          <= 1'b0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hblnk       <= hb_nxt;
            vblnk       <= vb_nxt;
            hsync       <= hs_nxt ^ ~HSYNC_POL;
            vsync       <= vs_nxt ^ ~VSYNC_POL;
            de          <= ~hb_nxt & ~vb_nxt;
            frame_start <= h_wrap & v_wrap;
            line_start  <= h_wrap;
        end else begin
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end
    end

    // Config path: accept into the shadow when free, promote it at frame wrap.
    // Accept and apply are exclusive since one needs the shadow empty, the
    // other full; a transfer landing on a wrap therefore waits a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cfg   <= RST_CFG;
            shd_cfg   <= '0;
            cfg_ready <= 1'b1;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                shd_cfg   <= cfg_in;
                cfg_ready <= 1'b0;
            end else if (apply) begin
                act_cfg   <= shd_cfg;
                cfg_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_prog.sv
// Scoreboard bench for vga_timing_prog. The driver issues one pixel-clock
// vector per cycle and queues the response the timing rules predict; a
// separate monitor pops and compares after every rising edge.
module tb_vga_timing_prog;
    import vga_pkg::*;

    localparam bit HP = 1'b0;  // active-low hsync in this build
    localparam bit VP = 1'b1;  // active-high vsync

    // Small reset timing so whole frames fit in a short run.
    localparam vga_cfg_t CFG_A = '{h_total: 11'd12, h_blank_start: 11'd8,
        h_sync_start: 11'd9, h_sync_stop: 11'd11, v_total: 11'd5,
        v_blank_start: 11'd3, v_sync_start: 11'd4, v_sync_stop: 11'd5};
    localparam vga_cfg_t CFG_B = '{h_total: 11'd8, h_blank_start: 11'd6,
        h_sync_start: 11'd6, h_sync_stop: 11'd7, v_total: 11'd4,
        v_blank_start: 11'd3, v_sync_start: 11'd3, v_sync_stop: 11'd4};

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic hb, vb, hs, vs, de, fs, ls, rdy, err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    vga_cfg_t    cfg_in;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [10:0] hcount, vcount;
    logic        hblnk, vblnk, hsync, vsync, de, frame_start, line_start, cfg_err;

    int   n_vec = 0;
    int   n_err = 0;
    obs_t q[$];

    // reference state
    int       m_h, m_v;
    vga_cfg_t m_act, m_sh;
    bit       m_full;

    vga_timing_prog #(.CNT_W(11), .HSYNC_POL(HP), .VSYNC_POL(VP), .RST_CFG(CFG_A)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cfg_in(cfg_in), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .hcount(hcount), .vcount(vcount), .hblnk(hblnk),
        .vblnk(vblnk), .hsync(hsync), .vsync(vsync), .de(de),
        .frame_start(frame_start), .line_start(line_start), .cfg_err(cfg_err));

    always #5 clk = ~clk;

    function automatic obs_t dut_obs();
        return {hcount, vcount, hblnk, vblnk, hsync, vsync, de,
                frame_start, line_start, cfg_ready, cfg_err};
    endfunction

    function automatic bit in_rng(input int x, input int lo, input int hi_excl);
        return (x >= lo) && (x < hi_excl);
    endfunction

    function automatic bit legal_ref(input vga_cfg_t c);
        return (c.h_total >= 2) && (c.v_total >= 2) &&
               (c.h_blank_start <= c.h_total) && (c.h_sync_start <= c.h_total) &&
               (c.h_sync_stop <= c.h_total) && (c.v_blank_start <= c.v_total) &&
               (c.v_sync_start <= c.v_total) && (c.v_sync_stop <= c.v_total) &&
               (c.h_sync_stop > c.h_sync_start) && (c.v_sync_stop > c.v_sync_start);
    endfunction

    // Expected outputs at the reference position under the reference config.
    function automatic obs_t predict(input bit fs, input bit ls, input bit err);
        obs_t o;
        bit hs_on, vs_on;
        o.h   = 11'(m_h);
        o.v   = 11'(m_v);
        o.hb  = in_rng(m_h, int'(m_act.h_blank_start), int'(m_act.h_total));
        o.vb  = in_rng(m_v, int'(m_act.v_blank_start), int'(m_act.v_total));
        hs_on = in_rng(m_h, int'(m_act.h_sync_start), int'(m_act.h_sync_stop));
        vs_on = in_rng(m_v, int'(m_act.v_sync_start), int'(m_act.v_sync_stop));
        o.hs  = hs_on ? HP : ~HP;
        o.vs  = vs_on ? VP : ~VP;
        o.de  = ~o.hb & ~o.vb;
        o.fs  = fs;
        o.ls  = ls;
        o.rdy = ~m_full;
        o.err = err;
        return o;
    endfunction

    function automatic void compare(input string name, input obs_t got, input obs_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h (h=%0d v=%0d) expected %h (h=%0d v=%0d)",
                     name, n_vec, got, got.h, got.v, exp, exp.h, exp.v);
        end
    endfunction

    // One clock of stimulus; the predicted post-edge response is queued.
    task automatic step(input bit e, input bit v, input vga_cfg_t c);
        bit xfer, ok, fs, ls;
        @(negedge clk);
        en = e; cfg_valid = v; cfg_in = c;
        xfer = v && !m_full;
        ok = 1'b1;
`ifdef VGA_TIMING_CFG_CHECK_EN
        ok = legal_ref(c);
`endif
        fs = 1'b0; ls = 1'b0;
        if (e) begin
            if (m_h == int'(m_act.h_total) - 1) begin
                m_h = 0;
                ls  = 1'b1;
                m_v = (m_v == int'(m_act.v_total) - 1) ? 0 : m_v + 1;
                if (m_v == 0) begin
                    fs = 1'b1;
                    if (m_full) begin m_act = m_sh; m_full = 1'b0; end
                end
            end else begin
                m_h++;
            end
        end
        if (xfer && ok) begin m_sh = c; m_full = 1'b1; end
        q.push_back(predict(fs, ls, xfer && !ok));
    endtask

    // Advance until the reference sits on the last position of the frame.
    task automatic run_to_last();
        for (int i = 0; i < 20000; i++) begin
            if (m_h == int'(m_act.h_total) - 1 && m_v == int'(m_act.v_total) - 1) break;
            step(1'b1, 1'b0, CFG_A);
        end
    endtask

    function automatic obs_t reset_obs();
        obs_t o;
        o = '0;
        o.hs = ~HP; o.vs = ~VP; o.rdy = 1'b1;
        return o;
    endfunction

    // Asynchronous reset in the middle of a cycle, release on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2;
        en = 1'b0; cfg_valid = 1'b0; rst_n = 1'b0;
        #1;
        compare("async_reset", dut_obs(), reset_obs());
        m_h = 0; m_v = 0; m_act = CFG_A; m_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every queued response just after the edge it belongs to.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) compare("cycle", dut_obs(), q.pop_front());
    end

    initial begin
        vga_cfg_t bad;
        rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_in = '0;
        m_h = 0; m_v = 0; m_act = CFG_A; m_sh = '0; m_full = 1'b0;
        #23;
        compare("power_on_reset", dut_obs(), reset_obs());
        @(negedge clk);
        rst_n = 1'b1;

        // Reset timing, then a short freeze mid-line.
        repeat (25) step(1'b1, 1'b0, CFG_A);
        repeat (4)  step(1'b0, 1'b0, CFG_A);

        // Mid-frame load of B; a second offer while the shadow is full is ignored.
        step(1'b1, 1'b1, CFG_B);
        repeat (3) step(1'b1, 1'b1, CFG_A);
        run_to_last();
        repeat (41) step(1'b1, 1'b0, CFG_A);

        // Transfer on the very edge that wraps to (0,0): B runs one more frame.
        run_to_last();
        step(1'b1, 1'b1, CFG_A);
        repeat (45) step(1'b1, 1'b0, CFG_A);

        // Freeze on the last position, then resume into frame_start.
        run_to_last();
        repeat (10) step(1'b0, 1'b0, CFG_A);
        repeat (3)  step(1'b1, 1'b0, CFG_A);

`ifdef VGA_TIMING_CFG_CHECK_EN
        bad = CFG_B;
        bad.h_sync_stop = bad.h_sync_start;
        step(1'b1, 1'b1, bad);
        repeat (3) step(1'b1, 1'b0, CFG_A);
        run_to_last();
        repeat (5) step(1'b1, 1'b0, CFG_A);
`else
        bad = '0;
        cfg_in = bad;
`endif

        // Full 1024x768 line after a boundary switch.
        step(1'b1, 1'b1, VGA_CFG_1024X768);
        run_to_last();
        repeat (1400) step(1'b1, 1'b0, CFG_A);

        // Reset with a pending shadow: back to the reset timing, shadow dropped.
        step(1'b1, 1'b1, VGA_CFG_640X480);
        step(1'b1, 1'b0, CFG_A);
        do_reset();
        repeat (70) step(1'b1, 1'b0, CFG_A);

        // Mid-frame switch to 640x480; cover a whole line of it.
        step(1'b1, 1'b1, VGA_CFG_640X480);
        run_to_last();
        repeat (820) step(1'b1, 1'b0, CFG_A);

        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
